ysyx_22051013_divider: RTL and testbench



---
 rtl/ysyx_22051013_divider.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22051013_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_divider.sv
// ysyx_22051013_divider: iterative radix-2 restoring divider for RV64M
// DIV/DIVU/REM/REMU and the W-forms. One quotient bit per cycle; quotient and
// remainder are presented together for one cycle in DONE.
// Optional feature: define YSYX_22051013_DIV_FAST_EN to short-circuit
// divide-by-zero straight from IDLE to DONE.
module ysyx_22051013_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  input  logic        flush,
  input  logic        div_signed,
  input  logic        divw,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Partial remainder is always below the divisor, so 64 bits hold it; the
  // 65th bit only exists in the trial value below.
  logic [63:0] rem_q, rem_d;
  // Dividend shift register; quotient bits enter at the LSB.
  logic [63:0] dvd_q, dvd_d;
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] orig_q, orig_d;
  logic        sign_q_q, sign_q_d;
  logic        sign_r_q, sign_r_d;
  logic        zero_q, zero_d;
  logic        w_q, w_d;
  logic [63:0] quot_out_q, quot_out_d;
  logic [63:0] rem_out_q, rem_out_d;

  logic        accept;
  logic [63:0] op_dvd, op_dvs, abs_dvd, abs_dvs;
  logic        sd, sv, op_zero;
  logic [64:0] trial, trial_sub;
  logic        q_bit;
  logic [63:0] q_fix, r_fix;
  logic [5:0]  cnt_last;

  // Handshake and masked result outputs; flush kills the strobe immediately.
  always_comb begin
    div_ready = (state_q == S_IDLE) && !flush;
    out_valid = (state_q == S_DONE) && !flush;
    quotient  = out_valid ? quot_out_q : 64'd0;
    remainder = out_valid ? rem_out_q  : 64'd0;
  end

  // Operand preparation for the accept cycle: W-form extension and magnitudes.
  always_comb begin
    accept  = div_valid && div_ready;
    op_dvd  = divw ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
    op_dvs  = divw ? {{32{div_signed & divisor[31]}},  divisor[31:0]}  : divisor;
    sd      = div_signed & op_dvd[63];
    sv      = div_signed & op_dvs[63];
    abs_dvd = sd ? (64'd0 - op_dvd) : op_dvd;
    abs_dvs = sv ? (64'd0 - op_dvs) : op_dvs;
    op_zero = (op_dvs == 64'd0);
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial     = {rem_q, dvd_q[63]};
    q_bit     = (trial >= {1'b0, dvs_q});
    trial_sub = trial - {1'b0, dvs_q};
    cnt_last  = w_q ? 6'd31 : 6'd63;
  end

  // Final correction: restore signs, apply divide-by-zero values, W-extend.
  always_comb begin
    q_fix = (sign_q_q && !zero_q) ? (64'd0 - dvd_q) : dvd_q;
    r_fix = sign_r_q ? (64'd0 - rem_q) : rem_q;
    if (zero_q) begin
      q_fix = {64{1'b1}};
      r_fix = orig_q;
    end
    if (w_q) begin
      q_fix = {{32{q_fix[31]}}, q_fix[31:0]};
      r_fix = {{32{r_fix[31]}}, r_fix[31:0]};
    end
  end

  // Next-state and datapath update for the IDLE/DIV/FIX/DONE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    orig_d     = orig_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    zero_d     = zero_q;
    w_d        = w_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_q_d = sd ^ sv;
          sign_r_d = sd;
          zero_d   = op_zero;
          w_d      = divw;
          orig_d   = op_dvd;
          dvs_d    = abs_dvs;
          // W-form: park the 32 live bits at the top so they leave MSB first.
          dvd_d    = divw ? {abs_dvd[31:0], 32'd0} : abs_dvd;
          rem_d    = 64'd0;
          cnt_d    = 6'd0;
`ifdef YSYX_22051013_DIV_FAST_EN
          if (op_zero) begin
            state_d    = S_DONE;
            quot_out_d = {64{1'b1}};
            rem_out_d  = divw ? {{32{op_dvd[31]}}, op_dvd[31:0]} : op_dvd;
          end else begin
            state_d = S_DIV;
          end
`else
          state_d = S_DIV;
`endif
        end
      end
      S_DIV: begin
        rem_d = q_bit ? trial_sub[63:0] : trial[63:0];
        dvd_d = {dvd_q[62:0], q_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == cnt_last) state_d = S_FIX;
      end
      S_FIX: begin
        quot_out_d = q_fix;
        rem_out_d  = r_fix;
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 64'd0;
      dvd_q      <= 64'd0;
      dvs_q      <= 64'd0;
      orig_q     <= 64'd0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      zero_q     <= 1'b0;
      w_q        <= 1'b0;
      quot_out_q <= 64'd0;
      rem_out_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      orig_q     <= orig_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      zero_q     <= zero_d;
      w_q        <= w_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_divider.sv
// Directed bench for ysyx_22051013_divider: a vector table plus hand-written
// sequences for flush, back-to-back requests and mid-operation reset.
module tb_ysyx_22051013_divider;

  logic        clk = 1'b0;
  logic        rst, div_valid, flush, div_signed, divw;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;

`ifdef YSYX_22051013_DIV_FAST_EN
  localparam int ZLAT64 = 1;
  localparam int ZLAT32 = 1;
`else
  localparam int ZLAT64 = 66;
  localparam int ZLAT32 = 34;
`endif

  always #5 clk = ~clk;

  ysyx_22051013_divider dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .flush(flush),
    .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    string       name;
    logic        s;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] eq;
    logic [63:0] er;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its result; clean flags any nonzero
  // output outside the strobe or a bad cycle right after it.
  task automatic do_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] q, output logic [63:0] r,
                       output logic clean);
    int g;
    g = 0;
    clean = 1'b1;
    q = 64'd0;
    r = 64'd0;
    @(negedge clk);
    while (!div_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    div_signed = s; divw = w; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    dividend = 64'hDEAD_BEEF_0BAD_F00D;
    divisor  = 64'h0123_4567_89AB_CDEF;
    lat = 1;
    while (lat < 300) begin
      @(negedge clk);
      if (out_valid) begin
        q = quotient;
        r = remainder;
        break;
      end
      if (quotient != 64'd0 || remainder != 64'd0) clean = 1'b0;
      @(posedge clk);
      lat++;
    end
    if (lat >= 300) lat = -1;
    @(posedge clk);
    @(negedge clk);
    if (out_valid || !div_ready || quotient != 64'd0 || remainder != 64'd0) clean = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] q, r;
    logic clean;
    logic seen;

    vecs[0]  = '{"divu_100_7",   1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
    vecs[1]  = '{"div_m7_2",     1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[2]  = '{"div_7_m2",     1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
    vecs[3]  = '{"divw_ovf",     1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 34};
    vecs[4]  = '{"divuw_max_1",  1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34};
    vecs[5]  = '{"div_5_0",      1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, ZLAT64};
    vecs[6]  = '{"divu_5_0",     1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, ZLAT64};
    vecs[7]  = '{"div_ovf64",    1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0, 66};
    vecs[8]  = '{"divu_big_16",  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 66};
    vecs[9]  = '{"divw_m7_2",    1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[10] = '{"divuw_8m_3",   1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd3,
                 64'h0000_0000_2AAA_AAAA, 64'd2, 34};
    vecs[11] = '{"divw_zero",    1'b1, 1'b1, 64'h0000_0000_8000_0005, 64'hABCD_0000_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, ZLAT32};

    rst = 1'b1; div_valid = 1'b0; flush = 1'b0; div_signed = 1'b0; divw = 1'b0;
    dividend = 64'd0; divisor = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {63'd0, div_ready}, 64'd1);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_quot", quotient, 64'd0);
    chk("reset_rem", remainder, 64'd0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].b, lat, q, r, clean);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, "_quot"}, q, vecs[i].eq);
      chk({vecs[i].name, "_rem"}, r, vecs[i].er);
      chk({vecs[i].name, "_quiet"}, {63'd0, clean}, 64'd1);
      $display("op %0d %s: lat=%0d q=%h r=%h", i, vecs[i].name, lat, q, r);
    end

    // Flush at accept+10: no result, ready again next cycle.
    @(negedge clk);
    div_signed = 1'b0; divw = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", {63'd0, div_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_next", {63'd0, div_ready}, 64'd1);
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);
    do_op(1'b0, 1'b0, 64'd9, 64'd4, lat, q, r, clean);
    chk("post_flush_lat", 64'(lat), 64'd66);
    chk("post_flush_quot", q, 64'd2);
    chk("post_flush_rem", r, 64'd1);
    $display("flush sequence: post-flush q=%h r=%h lat=%0d", q, r, lat);

    // flush together with div_valid in IDLE drops the request.
    @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; dividend = 64'd100; divisor = 64'd7;
    @(posedge clk);
    #1 begin flush = 1'b0; div_valid = 1'b0; end
    @(negedge clk);
    chk("flush_drops_req", {63'd0, div_ready}, 64'd1);
    $display("flush+valid: ready=%0d", div_ready);

    // div_valid held high: operands change while busy, second accepted at +67.
    @(negedge clk);
    div_signed = 1'b0; divw = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk);
    #1 begin dividend = 64'd9; divisor = 64'd4; end
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("hold_first_lat", 64'(lat), 64'd66);
    chk("hold_first_quot", quotient, 64'd14);
    chk("hold_first_rem", remainder, 64'd2);
    @(posedge clk);
    lat++;
    while (lat < 300) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("hold_second_lat", 64'(lat), 64'd133);
    chk("hold_second_quot", quotient, 64'd2);
    chk("hold_second_rem", remainder, 64'd1);
    $display("held valid: second result at +%0d q=%h r=%h", lat, quotient, remainder);
    div_valid = 1'b0;
    @(posedge clk);

    // rst mid-DIV returns everything to reset values.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {63'd0, div_ready}, 64'd1);
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_quot", quotient, 64'd0);
    chk("rst_mid_rem", remainder, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_result", {63'd0, seen}, 64'd0);
    $display("rst mid-op: ready=%0d out_valid_seen=%0d", div_ready, seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
